// File: rtl/imem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// imem_arbiter_pkg
//   Shared definitions for the instruction-memory arbiter slice: default
//   memory geometry, counter widths, the 2-bit FSM state codes and a small
//   state-decode helper.
// ----------------------------------------------------------------------------
package imem_arbiter_pkg;

    // Default instruction memory geometry.
    localparam int MEM_ADDR_LEN  = 16;
    localparam int INST_WORD_LEN = 32;

    // Read-latency down-counter and loader run counter widths (values 0..7).
    localparam int LAT_CNT_W = 3;
    localparam int RUN_CNT_W = 3;

    // FSM state codes, kept as plain constants for legacy compatibility.
    localparam logic [1:0] IMEM_ST_IDLE    = 2'd0;
    localparam logic [1:0] IMEM_ST_RD      = 2'd1;
    localparam logic [1:0] IMEM_ST_RD_WAIT = 2'd2;
    localparam logic [1:0] IMEM_ST_WR      = 2'd3;

    // True while a fetch read owns the memory pipeline.
    function automatic logic is_read_state(input logic [1:0] st);
        return (st == IMEM_ST_RD) || (st == IMEM_ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/imem_rd_tracker.sv
// ----------------------------------------------------------------------------
// imem_rd_tracker
//   Tracks one in-flight fetch read: a latency down-counter that times the
//   sample point of mem_rdata, and a drop flag that remembers a jump flush so
//   the returning word is discarded.
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous, active-low reset
//     rd_start   in   read granted this cycle (counter loads READ_LAT)
//     rd_active  in   FSM is in RD or RD_WAIT
//     rd_wait    in   FSM is in RD_WAIT
//     f_flush    in   jump taken: discard the in-flight read
//     rd_done    out  last RD_WAIT cycle; mem_rdata is valid now
//     rd_drop    out  the current read must not produce f_valid
// ----------------------------------------------------------------------------
module imem_rd_tracker
    import imem_arbiter_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_start,
    input  logic rd_active,
    input  logic rd_wait,
    input  logic f_flush,
    output logic rd_done,
    output logic rd_drop
);

    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 drop_q;

    // The counter holds READ_LAT during RD, so it reaches zero in the cycle
    // the memory presents the word: READ_LAT cycles after the RD cycle.
    assign rd_done = rd_wait && (lat_cnt == '0);

    // A flush in the very cycle the data is sampled must also suppress it,
    // hence the combinational term next to the stored flag.
    assign rd_drop = drop_q || (rd_active && f_flush);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (rd_start) begin
                lat_cnt <= LAT_CNT_W'(READ_LAT);
            end else if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_CNT_W'(1);
            end

            if (rd_start || rd_done) begin
                drop_q <= 1'b0;
            end else if (rd_active && f_flush) begin
                drop_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
//   Controller for the single-port instruction memory shared by the fetch
//   stage (reads, one outstanding) and the program loader (writes). Arbitrates
//   in IDLE, sequences the fixed-latency read pipeline, returns fetch data and
//   discards reads made stale by a jump flush. All outputs are registered.
//
//   Build option
//     STARVE_GUARD_EN  when defined, after MAX_RUN consecutive loader grants
//                      with f_req pending the next grant goes to fetch.
//                      When undefined the loader has strict priority.
//
//   Ports
//     clk, rst                   clock / asynchronous active-low reset
//     f_req, f_addr, f_flush     fetch read request, address, jump flush
//     f_ack, f_valid, f_data     fetch accept pulse, data pulse, read word
//     l_req, l_addr, l_wdata     loader write request, address, data
//     l_ack                      loader write-performed pulse
//     mem_en, mem_we, mem_addr,  memory access strobe, write enable,
//     mem_wdata, mem_rdata       address, write data, read data
//     busy                       FSM not in IDLE
// ----------------------------------------------------------------------------
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_LEN,
    parameter int DATA_W   = INST_WORD_LEN,
    parameter int READ_LAT = 2,
    parameter int MAX_RUN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_ack,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_data,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Both counters are 3 bits wide; reject configurations they cannot hold.
    if (READ_LAT < 1 || READ_LAT > 7 || MAX_RUN < 1 || MAX_RUN > 7) begin : g_bad_param
        $error("imem_arbiter: READ_LAT and MAX_RUN must be in 1..7");
    end

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       in_idle;
    logic       force_fetch;
    logic       grant_wr;
    logic       grant_rd;
    logic       rd_done;
    logic       rd_drop;
    logic       deliver;

    assign in_idle  = (state_q == IMEM_ST_IDLE);
    assign grant_wr = in_idle && l_req && !force_fetch;
    assign grant_rd = in_idle && f_req && !grant_wr;
    assign deliver  = rd_done && !rd_drop;

`ifdef STARVE_GUARD_EN
    logic [RUN_CNT_W-1:0] run_q;

    // Counts loader grants that bypassed a waiting fetch; any fetch grant or
    // an idle fetch side restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= '0;
        end else if (grant_rd || !f_req) begin
            run_q <= '0;
        end else if (grant_wr) begin
            run_q <= run_q + RUN_CNT_W'(1);
        end
    end

    assign force_fetch = f_req && (run_q == RUN_CNT_W'(MAX_RUN));
`else
    assign force_fetch = 1'b0;
`endif

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IMEM_ST_IDLE: begin
                if (grant_wr) begin
                    state_d = IMEM_ST_WR;
                end else if (grant_rd) begin
                    state_d = IMEM_ST_RD;
                end
            end
            IMEM_ST_RD:      state_d = IMEM_ST_RD_WAIT;
            IMEM_ST_RD_WAIT: if (rd_done) state_d = IMEM_ST_IDLE;
            IMEM_ST_WR:      state_d = IMEM_ST_IDLE;
            default:         state_d = IMEM_ST_IDLE;
        endcase
    end

    imem_rd_tracker #(
        .READ_LAT (READ_LAT)
    ) u_rd_tracker (
        .clk       (clk),
        .rst       (rst),
        .rd_start  (grant_rd),
        .rd_active (is_read_state(state_q)),
        .rd_wait   (state_q == IMEM_ST_RD_WAIT),
        .f_flush   (f_flush),
        .rd_done   (rd_done),
        .rd_drop   (rd_drop)
    );

    // NOTE: the datapath registers (f_data, mem_addr, mem_wdata) are reset too,
    // because every output must read 0 while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IMEM_ST_IDLE;
            f_ack     <= 1'b0;
            l_ack     <= 1'b0;
            f_valid   <= 1'b0;
            f_data    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IMEM_ST_IDLE);

            // Access outputs are driven by the grant so they appear in the
            // RD/WR cycle itself; they fall back to 0 in every other cycle.
            f_ack  <= grant_rd;
            l_ack  <= grant_wr;
            mem_en <= grant_rd || grant_wr;
            mem_we <= grant_wr;

            if (grant_wr) begin
                mem_addr  <= l_addr;
                mem_wdata <= l_wdata;
            end else if (grant_rd) begin
                mem_addr <= f_addr;
            end

            f_valid <= deliver;
            if (deliver) begin
                f_data <= mem_rdata;
            end
        end
    end

endmodule
